// File: rtl/mem_access.sv
// Memory-access pipeline stage: serialises LB/LH/LW/SB/SH/SW
// over an 8-bit memory port, stalling the pipeline until done.
module mem_access #(
    parameter int            OP_W   = 4,
    parameter logic [OP_W-1:0] OP_LB  = OP_W'(1),
    parameter logic [OP_W-1:0] OP_LH  = OP_W'(2),
    parameter logic [OP_W-1:0] OP_LW  = OP_W'(3),
    parameter logic [OP_W-1:0] OP_LBU = OP_W'(4),
    parameter logic [OP_W-1:0] OP_LHU = OP_W'(5),
    parameter logic [OP_W-1:0] OP_SB  = OP_W'(6),
    parameter logic [OP_W-1:0] OP_SH  = OP_W'(7),
    parameter logic [OP_W-1:0] OP_SW  = OP_W'(8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    input  logic [31:0]     wdata_i,
    input  logic [31:0]     mmem_data_i,
    input  logic [OP_W-1:0] op_type_i,
    input  logic [7:0]      mem_din_i,
    output logic [31:0]     mem_a_o,
    output logic [7:0]      mem_dout_o,
    output logic            mem_wr_o,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [31:0]     wdata_o,
    output logic            stallreq_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STORE
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [23:0] r_buf;

    logic        w_load;
    logic        w_store;
    logic [2:0]  w_n;
    logic [2:0]  w_n_m1;
    logic [31:0] w_addr;
    logic [31:0] w_st_shift;
    logic [31:0] w_ld_word;

    always_comb begin
        w_load  = 1'b0;
        w_store = 1'b0;
        w_n     = 3'd1;
        unique case (1'b1)
            op_type_i == OP_LB,
            op_type_i == OP_LBU: begin
                w_load = 1'b1;
                w_n    = 3'd1;
            end
            op_type_i == OP_LH,
            op_type_i == OP_LHU: begin
                w_load = 1'b1;
                w_n    = 3'd2;
            end
            op_type_i == OP_LW: begin
                w_load = 1'b1;
                w_n    = 3'd4;
            end
            op_type_i == OP_SB: begin
                w_store = 1'b1;
                w_n     = 3'd1;
            end
            op_type_i == OP_SH: begin
                w_store = 1'b1;
                w_n     = 3'd2;
            end
            op_type_i == OP_SW: begin
                w_store = 1'b1;
                w_n     = 3'd4;
            end
            default: ;
        endcase
    end

    assign w_n_m1     = w_n - 3'd1;
    assign w_addr     = wdata_i + {29'd0, r_cnt};
    assign w_st_shift = mmem_data_i >> {r_cnt, 3'b000};

    // The final byte arrives on mem_din_i; earlier ones sit in r_buf.
    always_comb begin
        w_ld_word = {mem_din_i, r_buf};
        unique case (1'b1)
            op_type_i == OP_LB:
                w_ld_word = {{24{mem_din_i[7]}}, mem_din_i};
            op_type_i == OP_LBU:
                w_ld_word = {24'd0, mem_din_i};
            op_type_i == OP_LH:
                w_ld_word = {{16{mem_din_i[7]}}, mem_din_i, r_buf[7:0]};
            op_type_i == OP_LHU:
                w_ld_word = {16'd0, mem_din_i, r_buf[7:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_buf   <= 24'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_cnt   <= 3'd1;
                        r_state <= S_LOAD;
                    end else if (w_store && w_n != 3'd1) begin
                        r_cnt   <= 3'd1;
                        r_state <= S_STORE;
                    end
                end
                S_LOAD: begin
                    if (r_cnt == w_n) begin
                        r_cnt   <= 3'd0;
                        r_state <= S_IDLE;
                    end else begin
                        unique case (r_cnt)
                            3'd1:    r_buf[7:0]   <= mem_din_i;
                            3'd2:    r_buf[15:8]  <= mem_din_i;
                            3'd3:    r_buf[23:16] <= mem_din_i;
                            default: ;
                        endcase
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_STORE: begin
                    if (r_cnt == w_n_m1) begin
                        r_cnt   <= 3'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    r_cnt   <= 3'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_a_o    = 32'd0;
        mem_dout_o = 8'd0;
        mem_wr_o   = 1'b0;
        wd_o       = 5'd0;
        wreg_o     = 1'b0;
        wdata_o    = 32'd0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o = wd_i;
            unique case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        mem_a_o    = wdata_i;
                        stallreq_o = 1'b1;
                    end else if (w_store) begin
                        mem_wr_o   = 1'b1;
                        mem_a_o    = wdata_i;
                        mem_dout_o = mmem_data_i[7:0];
                        stallreq_o = (w_n != 3'd1);
                    end else begin
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end
                end
                S_LOAD: begin
                    if (r_cnt == w_n) begin
                        wreg_o  = wreg_i;
                        wdata_o = w_ld_word;
                    end else begin
                        mem_a_o    = w_addr;
                        stallreq_o = 1'b1;
                    end
                end
                S_STORE: begin
                    mem_wr_o   = 1'b1;
                    mem_a_o    = w_addr;
                    mem_dout_o = w_st_shift[7:0];
                    stallreq_o = (r_cnt != w_n_m1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a byte-wide memory model
// that returns read data one cycle after the address.
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [31:0] mmem_data_i;
    logic [3:0]  op_type_i;
    logic [7:0]  mem_din_i;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic        mem_wr_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [logic [31:0]];

    mem_access dut (
        .clk         (clk),
        .rst         (rst),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .mmem_data_i (mmem_data_i),
        .op_type_i   (op_type_i),
        .mem_din_i   (mem_din_i),
        .mem_a_o     (mem_a_o),
        .mem_dout_o  (mem_dout_o),
        .mem_wr_o    (mem_wr_o),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stallreq_o  (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_din_i <= mem.exists(mem_a_o) ? mem[mem_a_o] : 8'h00;
        if (mem_wr_o) mem[mem_a_o] = mem_dout_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic st,
                        input logic wr, input logic chka,
                        input logic [31:0] a, input logic [7:0] d,
                        input logic wreg, input logic [31:0] wdata);
        @(negedge clk);
        chk({tag, "_stall"}, {31'd0, stallreq_o}, {31'd0, st});
        chk({tag, "_wr"}, {31'd0, mem_wr_o}, {31'd0, wr});
        chk({tag, "_wreg"}, {31'd0, wreg_o}, {31'd0, wreg});
        if (st || wr || chka)
            chk({tag, "_a"}, mem_a_o, a);
        if (wr)
            chk({tag, "_dout"}, {24'd0, mem_dout_o}, {24'd0, d});
        if (wreg) begin
            chk({tag, "_wdata"}, wdata_o, wdata);
            chk({tag, "_wd"}, {27'd0, wd_o}, {27'd0, wd_i});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, stallreq_o}, 32'd0);
        chk({tag, "_wr"}, {31'd0, mem_wr_o}, 32'd0);
        chk({tag, "_a"}, mem_a_o, 32'd0);
        chk({tag, "_dout"}, {24'd0, mem_dout_o}, 32'd0);
        chk({tag, "_wreg"}, {31'd0, wreg_o}, 32'd0);
        chk({tag, "_wd"}, {27'd0, wd_o}, 32'd0);
        chk({tag, "_wdata"}, wdata_o, 32'd0);
    endtask

    initial begin
        mem[32'h100] = 8'h11;
        mem[32'h101] = 8'h22;
        mem[32'h102] = 8'h33;
        mem[32'h103] = 8'h44;
        mem[32'h20]  = 8'h80;
        mem[32'h30]  = 8'hFE;
        mem[32'h31]  = 8'hFF;

        rst         = 1'b1;
        op_type_i   = 4'd0;
        wd_i        = 5'h1f;
        wreg_i      = 1'b1;
        wdata_i     = 32'h55;
        mmem_data_i = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;

        rst     = 1'b0;
        wd_i    = 5'd3;
        wdata_i = 32'h1234;
        step("nonmem", 0, 0, 1, 32'h0, 8'h0, 1, 32'h1234);

        op_type_i = 4'd3;
        wd_i      = 5'd7;
        wdata_i   = 32'h100;
        step("lw0", 1, 0, 1, 32'h100, 8'h0, 0, 32'h0);
        step("lw1", 1, 0, 1, 32'h101, 8'h0, 0, 32'h0);
        step("lw2", 1, 0, 1, 32'h102, 8'h0, 0, 32'h0);
        step("lw3", 1, 0, 1, 32'h103, 8'h0, 0, 32'h0);
        step("lw4", 0, 0, 0, 32'h0, 8'h0, 1, 32'h4433_2211);

        op_type_i = 4'd1;
        wdata_i   = 32'h20;
        step("lb0", 1, 0, 1, 32'h20, 8'h0, 0, 32'h0);
        step("lb1", 0, 0, 0, 32'h0, 8'h0, 1, 32'hFFFF_FF80);

        op_type_i = 4'd4;
        step("lbu0", 1, 0, 1, 32'h20, 8'h0, 0, 32'h0);
        step("lbu1", 0, 0, 0, 32'h0, 8'h0, 1, 32'h0000_0080);

        op_type_i = 4'd5;
        wdata_i   = 32'h30;
        step("lhu0", 1, 0, 1, 32'h30, 8'h0, 0, 32'h0);
        step("lhu1", 1, 0, 1, 32'h31, 8'h0, 0, 32'h0);
        step("lhu2", 0, 0, 0, 32'h0, 8'h0, 1, 32'h0000_FFFE);

        op_type_i = 4'd2;
        step("lh0", 1, 0, 1, 32'h30, 8'h0, 0, 32'h0);
        step("lh1", 1, 0, 1, 32'h31, 8'h0, 0, 32'h0);
        step("lh2", 0, 0, 0, 32'h0, 8'h0, 1, 32'hFFFF_FFFE);

        op_type_i   = 4'd8;
        wdata_i     = 32'h200;
        mmem_data_i = 32'hDEAD_BEEF;
        step("sw0", 1, 1, 1, 32'h200, 8'hEF, 0, 32'h0);
        step("sw1", 1, 1, 1, 32'h201, 8'hBE, 0, 32'h0);
        step("sw2", 1, 1, 1, 32'h202, 8'hAD, 0, 32'h0);
        step("sw3", 0, 1, 1, 32'h203, 8'hDE, 0, 32'h0);
        chk("sw_mem", {mem[32'h203], mem[32'h202],
                       mem[32'h201], mem[32'h200]}, 32'hDEAD_BEEF);

        op_type_i   = 4'd6;
        wdata_i     = 32'h7;
        mmem_data_i = 32'h1234_5678;
        step("sb0", 0, 1, 1, 32'h7, 8'h78, 0, 32'h0);

        op_type_i = 4'd0;
        wdata_i   = 32'h99;
        step("after_sb", 0, 0, 1, 32'h0, 8'h0, 1, 32'h99);

        op_type_i   = 4'd7;
        wdata_i     = 32'hFFFF_FFFF;
        mmem_data_i = 32'h0000_ABCD;
        step("sh0", 1, 1, 1, 32'hFFFF_FFFF, 8'hCD, 0, 32'h0);
        step("sh1", 0, 1, 1, 32'h0000_0000, 8'hAB, 0, 32'h0);

        op_type_i   = 4'd8;
        wdata_i     = 32'h300;
        mmem_data_i = 32'h0102_0304;
        step("swr0", 1, 1, 1, 32'h300, 8'h04, 0, 32'h0);
        step("swr1", 1, 1, 1, 32'h301, 8'h03, 0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("mid_rst");
        @(posedge clk);
        #1;
        rst       = 1'b0;
        op_type_i = 4'd0;
        wd_i      = 5'd9;
        wdata_i   = 32'hCAFE;
        step("post_rst", 0, 0, 1, 32'h0, 8'h0, 1, 32'hCAFE);
        chk("rst_nowrite", {31'd0, mem.exists(32'h302)}, 32'd0);
        chk("rst_byte1", {24'd0, mem[32'h301]}, 32'h03);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
